// File: rtl/dcpu_pkg.sv
// Shared types and constants for the DCPU-16 execute-stage helpers.
// Includes a saturating 5-bit increment so counters need no '+' operator.
package dcpu_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } seq_state_e;

  localparam int MUL_ITERS = 16;
  localparam int DIV_ITERS = 32;

  // Ripple increment built from xor/and; holds at all-ones instead of wrapping.
  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    logic [4:0] r;
    logic       c;
    r = v;
    c = 1'b1;
    if (!(&v)) begin
      for (int i = 0; i < 5; i++) begin
        r[i] = v[i] ^ c;
        c    = v[i] & c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/add16.sv
// 16-bit adder: four 4-bit carry-lookahead groups with the group carries rippled.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Each group resolves its four carries in parallel from its incoming carry.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 16; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/DIV sequencer for DCPU-16 sharing one add16.
// MUL is shift-add over 16 cycles; DIV is restoring division of {b,16'h0} over 32.
module muldiv_seq
  import dcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] op_b,
  input  logic [15:0] op_a,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic [15:0] ex
);

  seq_state_e  state;
  seq_state_e  state_next;
  logic [4:0]  cnt;
  logic [15:0] acc;
  logic [15:0] opnd;
  logic [31:0] shreg;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  logic        div_zero;
  logic        last_iter;
  logic        div_ok;
  logic [15:0] mul_hi_next;
  logic [15:0] mul_lo_next;
  logic [15:0] div_r_next;
  logic [31:0] div_q_next;

  assign div_zero  = (op_e'(op) == OP_DIV) && (op_a == 16'h0000);
  assign last_iter = ((state == MUL) && (cnt == 5'(MUL_ITERS - 1)))
                   || ((state == DIV) && (cnt == 5'(DIV_ITERS - 1)));

  // acc is the high product half in MUL and the partial remainder in DIV.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      MUL: begin
        add_a = acc;
        add_b = shreg[0] ? opnd : 16'h0000;
      end
      DIV: begin
        add_a   = {acc[14:0], shreg[31]};
        add_b   = ~opnd;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  add16 u_add16 (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Bit 16 of the shifted remainder forces success: the true difference is then positive.
  assign div_ok      = acc[15] | add_cout;
  assign mul_hi_next = {add_cout, add_sum[15:1]};
  assign mul_lo_next = {add_sum[0], shreg[15:1]};
  assign div_r_next  = div_ok ? add_sum : add_a;
  assign div_q_next  = {shreg[30:0], div_ok};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (div_zero)                    state_next = DONE;
          else if (op_e'(op) == OP_DIV)    state_next = DIV;
          else                             state_next = MUL;
        end
      end
      MUL:     if (last_iter) state_next = DONE;
      DIV:     if (last_iter) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result and ex are loaded on the edge that enters DONE and then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      shreg  <= '0;
      result <= '0;
      ex     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            acc <= '0;
            if (op_e'(op) == OP_DIV) begin
              opnd  <= op_a;
              shreg <= {op_b, 16'h0000};
            end else begin
              opnd  <= op_b;
              shreg <= {16'h0000, op_a};
            end
            if (div_zero) begin
              result <= '0;
              ex     <= '0;
            end
          end
        end
        MUL: begin
          acc          <= mul_hi_next;
          shreg[15:0]  <= mul_lo_next;
          cnt          <= sat_inc5(cnt);
          if (last_iter) begin
            result <= mul_lo_next;
            ex     <= mul_hi_next;
          end
        end
        DIV: begin
          acc   <= div_r_next;
          shreg <= div_q_next;
          cnt   <= sat_inc5(cnt);
          if (last_iter) begin
            result <= div_q_next[31:16];
            ex     <= div_q_next[15:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
